// File: rtl/ciclo_lavagem.sv
// Wash-cycle sequencer: waits for the delay-start handshake, then steps
// through fill, wash, rinse and spin. Each phase lasts a fixed number of
// unpaused cycles, and the sequencer drives the actuators for each phase.
module ciclo_lavagem #(
  parameter int unsigned T_ENCHER   = 4,
  parameter int unsigned T_LAVAR    = 8,
  parameter int unsigned T_ENXAGUAR = 6,
  parameter int unsigned T_CENTRIF  = 5,
  parameter int unsigned W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iniciar,
  input  logic       porta_fechada,
  input  logic       pausa,
  input  logic       cancelar,
  input  logic       pronto,
  output logic       iniciar_atraso,
  output logic       valvula,
  output logic       motor,
  output logic       bomba,
  output logic       centrifuga,
  output logic       fim,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    StOcioso      = 3'd0,
    StEspera      = 3'd1,
    StEncher      = 3'd2,
    StLavar       = 3'd3,
    StEnxaguar    = 3'd4,
    StCentrifugar = 3'd5,
    StFim         = 3'd6
  } estado_e;

  estado_e        state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           em_fase;
  logic           pausado;
  logic [W-1:0]   limite;

  // Phase classification and terminal count for the current phase
  always_comb begin
    em_fase = 1'b0;
    limite  = '0;
    case (state_q)
      StEncher:      begin em_fase = 1'b1; limite = W'(T_ENCHER - 1);   end
      StLavar:       begin em_fase = 1'b1; limite = W'(T_LAVAR - 1);    end
      StEnxaguar:    begin em_fase = 1'b1; limite = W'(T_ENXAGUAR - 1); end
      StCentrifugar: begin em_fase = 1'b1; limite = W'(T_CENTRIF - 1);  end
      default:       ;
    endcase
    // Pause and door only matter while a timed phase is running
    pausado = em_fase & (pausa | ~porta_fechada);
  end

  // Next-state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cancelar && state_q != StOcioso) begin
      state_d = StOcioso;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StOcioso: begin
          cnt_d = '0;
          if (iniciar && porta_fechada) state_d = StEspera;
        end
        StEspera: begin
          cnt_d = '0;
          if (pronto) state_d = StEncher;
        end
        StEncher, StLavar, StEnxaguar, StCentrifugar: begin
          if (!pausado) begin
            if (cnt_q == limite) begin
              cnt_d = '0;
              unique case (state_q)
                StEncher:   state_d = StLavar;
                StLavar:    state_d = StEnxaguar;
                StEnxaguar: state_d = StCentrifugar;
                default:    state_d = StFim;
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StFim: begin
          cnt_d = '0;
          // Require release of the button so a held start cannot re-arm
          if (!iniciar) state_d = StOcioso;
        end
        default: begin
          state_d = StOcioso;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOcioso;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from state; actuators are forced off while paused
  always_comb begin
    iniciar_atraso = 1'b0;
    valvula        = 1'b0;
    motor          = 1'b0;
    bomba          = 1'b0;
    centrifuga     = 1'b0;
    fim            = 1'b0;
    case (state_q)
      StEspera:      iniciar_atraso = 1'b1;
      StEncher: begin
        iniciar_atraso = 1'b1;
        valvula        = ~pausado;
      end
      StLavar: begin
        iniciar_atraso = 1'b1;
        motor          = ~pausado;
      end
      StEnxaguar: begin
        iniciar_atraso = 1'b1;
        valvula        = ~pausado;
        motor          = ~pausado;
      end
      StCentrifugar: begin
        iniciar_atraso = 1'b1;
        bomba          = ~pausado;
        centrifuga     = ~pausado;
      end
      StFim:         fim = 1'b1;
      default:       ;
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_ciclo_lavagem.sv
// Randomized bench for the wash-cycle sequencer against a phase/time model.
module tb_ciclo_lavagem;

  logic       clk = 1'b0;
  logic       rst, iniciar, porta_fechada, pausa, cancelar, pronto;
  logic       iniciar_atraso, valvula, motor, bomba, centrifuga, fim;
  logic [2:0] estado;

  int checks   = 0;
  int failures = 0;

  // Model: stage 0 idle, 1 waiting, 2..5 timed phases, 6 done
  int dur [4] = '{4, 8, 6, 5};
  int m_st;
  int m_elapsed;
  int saw_fim = 0;

  always #5 clk = ~clk;

  ciclo_lavagem dut (
    .clk            (clk),
    .rst            (rst),
    .iniciar        (iniciar),
    .porta_fechada  (porta_fechada),
    .pausa          (pausa),
    .cancelar       (cancelar),
    .pronto         (pronto),
    .iniciar_atraso (iniciar_atraso),
    .valvula        (valvula),
    .motor          (motor),
    .bomba          (bomba),
    .centrifuga     (centrifuga),
    .fim            (fim),
    .estado         (estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_st = 0; m_elapsed = 0;
    end else if (cancelar && m_st != 0) begin
      m_st = 0; m_elapsed = 0;
    end else if (m_st == 0) begin
      if (iniciar && porta_fechada) m_st = 1;
    end else if (m_st == 1) begin
      if (pronto) begin m_st = 2; m_elapsed = 0; end
    end else if (m_st <= 5) begin
      if (!pausa && porta_fechada) begin
        m_elapsed++;
        if (m_elapsed == dur[m_st-2]) begin m_st++; m_elapsed = 0; end
      end
    end else begin
      if (!iniciar) m_st = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       run;
    logic [5:0] exp, got;
    run = (m_st >= 2 && m_st <= 5) && !(pausa || !porta_fechada);
    exp[5] = (m_st >= 1 && m_st <= 5);
    exp[4] = run && (m_st == 2 || m_st == 4);
    exp[3] = run && (m_st == 3 || m_st == 4);
    exp[2] = run && (m_st == 5);
    exp[1] = run && (m_st == 5);
    exp[0] = (m_st == 6);
    got = {iniciar_atraso, valvula, motor, bomba, centrifuga, fim};
    check({tag, "_estado"}, 32'(estado), 32'(m_st));
    check({tag, "_outs"}, 32'(got), 32'(exp));
  endtask

  // Apply inputs, clock once, compare just after the edge
  task automatic step(input logic r, input logic ini, input logic door, input logic pa,
                      input logic ca, input logic pr, input string tag);
    rst = r; iniciar = ini; porta_fechada = door; pausa = pa; cancelar = ca; pronto = pr;
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    if (m_st == 6) saw_fim++;
  endtask

  initial begin
    m_st = 0; m_elapsed = 0;
    rst = 1; iniciar = 0; porta_fechada = 1; pausa = 0; cancelar = 0; pronto = 0;
    @(negedge clk);
    step(1, 0, 1, 0, 0, 0, "reset");
    // Directed normal run with no interruptions
    step(0, 0, 0, 0, 0, 1, "idle_pronto");
    step(0, 1, 0, 0, 0, 0, "idle_door_open");
    step(0, 1, 1, 0, 0, 0, "start");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, "espera");
    step(0, 1, 1, 0, 0, 1, "pronto");
    for (int i = 0; i < 23; i++) step(0, 1, 1, i == 9, 0, 0, "phases");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, "fim_held");
    step(0, 0, 1, 0, 0, 0, "fim_release");
    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 99) < 93,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 3) == 0,
           "rand");
    end
    check("reached_fim", 32'(saw_fim > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
